// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the iterative multiply/divide unit:
//               operand width, 3-bit operation encoding, FSM state encoding
//               and signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    // Operation encoding
    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;
    localparam logic [2:0] c_OP_REMU   = 3'd7;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Number of radix-2 iterations per operation
    localparam logic [5:0] c_STEPS = 6'd32;

    // srcA is treated as two's complement for these ops
    function automatic logic f_a_signed(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
               (op == c_OP_DIV)  || (op == c_OP_REM);
    endfunction

    // srcB is treated as two's complement for these ops
    function automatic logic f_b_signed(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/response handshake bundle of the multiply/divide
//               unit. The unit side uses the slave modport, the requester
//               side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = muldiv_pkg::XLEN
);
    logic            reqValid;
    logic            reqReady;
    logic [2:0]      op;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            respValid;
    logic            respReady;
    logic [XLEN-1:0] result;
    logic            busy;

    modport slave (
        input  reqValid, op, srcA, srcB, respReady,
        output reqReady, respValid, result, busy
    );

    modport master (
        output reqValid, op, srcA, srcB, respReady,
        input  reqReady, respValid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_signadj.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signadj
// Description : Sign handling around the unsigned iterative core: absolute
//               values of the incoming operands and conditional two's
//               complement negation of the raw double-width result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signadj #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  wire logic [XLEN-1:0]   i_a,
    input  wire logic [XLEN-1:0]   i_b,
    input  wire logic              i_a_signed,
    input  wire logic              i_b_signed,
    output logic      [XLEN-1:0]   o_abs_a,
    output logic      [XLEN-1:0]   o_abs_b,
    output logic                   o_neg_a,
    output logic                   o_neg_b,
    input  wire logic [2*XLEN-1:0] i_raw,
    input  wire logic              i_neg,
    output logic      [2*XLEN-1:0] o_fixed
);
    // An operand is negative only when its op interprets it as signed
    assign o_neg_a = i_a_signed & i_a[XLEN-1];
    assign o_neg_b = i_b_signed & i_b[XLEN-1];

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude
    assign o_abs_a = o_neg_a ? -i_a : i_a;
    assign o_abs_b = o_neg_b ? -i_b : i_b;

    // Final sign fix-up over the full product / zero-extended quotient
    assign o_fixed = i_neg ? -i_raw : i_raw;
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32-bit multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide on magnitudes, followed by a
//               single sign fix-up cycle. Divide-by-zero and signed overflow
//               complete in one cycle.
//               Build option MULDIV_FAST_MUL_EN: multiply ops use a
//               single-cycle 64-bit multiplier instead of the iterative path.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  wire logic clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [5:0]        r_cnt;
    logic [XLEN:0]     r_hi;      // partial product high / partial remainder
    logic [XLEN-1:0]   r_lo;      // multiplier / dividend-quotient
    logic [XLEN-1:0]   r_b;       // multiplicand / divisor magnitude
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_neg_a, w_neg_b, w_neg_in;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_b_zero, w_ovf, w_special, w_fast;
    logic [XLEN-1:0]   w_special_res, w_fast_res, w_fix_res;
    logic [2*XLEN-1:0] w_raw, w_fixed;

    logic              w_s_mul;
    logic [XLEN:0]     w_s_hi, w_sum, w_shift, w_diff, w_step_hi;
    logic [XLEN-1:0]   w_s_lo, w_s_b, w_step_lo;

    assign w_accept = bus.reqValid && (r_state == c_ST_IDLE);

    muldiv_signadj #(.XLEN(XLEN)) u_signadj (
        .i_a        (bus.srcA),
        .i_b        (bus.srcB),
        .i_a_signed (f_a_signed(bus.op)),
        .i_b_signed (f_b_signed(bus.op)),
        .o_abs_a    (w_abs_a),
        .o_abs_b    (w_abs_b),
        .o_neg_a    (w_neg_a),
        .o_neg_b    (w_neg_b),
        .i_raw      (w_raw),
        .i_neg      (r_neg),
        .o_fixed    (w_fixed)
    );

    // Remainders follow the dividend; products and quotients the sign XOR
    assign w_neg_in = (bus.op == c_OP_REM || bus.op == c_OP_REMU) ? w_neg_a
                                                                 : (w_neg_a ^ w_neg_b);

    // Divide corner cases resolved at accept without iterating
    assign w_b_zero  = bus.op[2] && (bus.srcB == '0);
    assign w_ovf     = (bus.op == c_OP_DIV || bus.op == c_OP_REM) &&
                       (bus.srcA == c_INT_MIN) && (bus.srcB == '1);
    assign w_special = w_b_zero || w_ovf;
    assign w_special_res = w_b_zero ? (bus.op[1] ? bus.srcA : '1)
                                    : (bus.op[1] ? '0 : c_INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
    assign w_fast_a    = {{XLEN{w_neg_a}}, bus.srcA};
    assign w_fast_b    = {{XLEN{w_neg_b}}, bus.srcB};
    assign w_fast_prod = w_fast_a * w_fast_b;
    assign w_fast      = ~bus.op[2];
    assign w_fast_res  = (bus.op == c_OP_MUL) ? w_fast_prod[XLEN-1:0]
                                              : w_fast_prod[2*XLEN-1:XLEN];
`else
    assign w_fast      = 1'b0;
    assign w_fast_res  = '0;
`endif

    // The first iteration runs on the accept edge straight from the
    // operand magnitudes, so 31 more steps plus the fix-up fit in CALC
    assign w_s_mul = w_accept ? ~bus.op[2] : ~r_op[2];
    assign w_s_hi  = w_accept ? '0 : r_hi;
    assign w_s_lo  = w_accept ? w_abs_a : r_lo;
    assign w_s_b   = w_accept ? w_abs_b : r_b;

    assign w_sum   = w_s_hi + (w_s_lo[0] ? {1'b0, w_s_b} : '0);
    assign w_shift = {w_s_hi[XLEN-1:0], w_s_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, w_s_b};

    assign w_step_hi = w_s_mul ? {1'b0, w_sum[XLEN:1]}
                               : (w_diff[XLEN] ? w_shift : w_diff);
    assign w_step_lo = w_s_mul ? {w_sum[0], w_s_lo[XLEN-1:1]}
                               : {w_s_lo[XLEN-2:0], ~w_diff[XLEN]};

    // Raw unsigned result chosen per op, then sign-corrected by the sub-module
    assign w_raw = (~r_op[2]) ? {r_hi[XLEN-1:0], r_lo}
                 : (r_op[1]  ? {{XLEN{1'b0}}, r_hi[XLEN-1:0]}
                             : {{XLEN{1'b0}}, r_lo});
    assign w_fix_res = (r_op[2] || r_op == c_OP_MUL) ? w_fixed[XLEN-1:0]
                                                     : w_fixed[2*XLEN-1:XLEN];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)
                           w_state_nxt = (w_special || w_fast) ? c_ST_DONE : c_ST_CALC;
            c_ST_CALC: if (r_cnt == c_STEPS) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (bus.respReady)    w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_neg <= w_neg_in;
            r_b   <= w_abs_b;
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= 6'd1;
            if (w_special)   r_result <= w_special_res;
            else if (w_fast) r_result <= w_fast_res;
        end else if (r_state == c_ST_CALC) begin
            if (r_cnt == c_STEPS) begin
                r_result <= w_fix_res;
            end else begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    assign bus.reqReady  = (r_state == c_ST_IDLE);
    assign bus.respValid = (r_state == c_ST_DONE);
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.result    = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed vectors,
//               handshake/back-pressure, reset abort and randomized ops
//               checked against a 64-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic t_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the ISA corner-case rules
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return c_FAST ? 1 : 33;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // One complete transaction; hold = cycles respReady stays low in DONE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int n;
        int lat;
        lat = exp_latency(op, a, b);
        @(negedge clk);
        t_check("req_ready_idle", bus.reqReady, 1);
        bus.reqValid = 1'b1;
        bus.op       = op;
        bus.srcA     = a;
        bus.srcB     = b;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        bus.op       = 3'($urandom_range(0, 7));
        bus.srcA     = $urandom;
        bus.srcB     = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                t_check("busy_after_accept", bus.busy, 1);
                t_check("req_ready_after_accept", bus.reqReady, 0);
            end
        end while (!bus.respValid && n < 60);
        t_check($sformatf("latency op%0d", op), 64'(n), 64'(lat));
        t_check($sformatf("result op%0d a=%h b=%h", op, a, b), bus.result, exp);
        for (int i = 0; i < hold; i++) begin
            bus.srcA = $urandom;
            @(negedge clk);
            t_check("hold_valid", bus.respValid, 1);
            t_check("hold_result", bus.result, exp);
            t_check("hold_req_ready", bus.reqReady, 0);
        end
        bus.respReady = 1'b1;
        @(posedge clk);
        #1;
        bus.respReady = 1'b0;
        @(negedge clk);
        t_check("req_ready_after_resp", bus.reqReady, 1);
        t_check("valid_after_resp", bus.respValid, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.reqValid  = 1'b0;
        bus.respReady = 1'b0;
        bus.op        = 3'd0;
        bus.srcA      = '0;
        bus.srcB      = '0;
        #1;
        t_check("rst_req_ready", bus.reqReady, 1);
        t_check("rst_resp_valid", bus.respValid, 0);
        t_check("rst_busy", bus.busy, 0);
        t_check("rst_result", bus.result, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // respReady outside DONE has no effect
        bus.respReady = 1'b1;
        repeat (3) @(negedge clk);
        t_check("idle_resp_ready_ignored", {bus.reqReady, bus.busy, bus.respValid}, 3'b100);
        bus.respReady = 1'b0;

        // Directed vectors
        run_op(3'd0, 32'd10,         32'd20,         32'd200,        0);
        run_op(3'd1, 32'd100000,     32'hFFFF_FFFE,  32'hFFFF_FFFF,  0);
        run_op(3'd2, 32'hFFFF_FFF6,  32'd3,          32'hFFFF_FFFF,  0);
        run_op(3'd3, 32'd300000,     32'd2000,       32'd0,          0);
        run_op(3'd4, 32'd100,        32'hFFFF_FFFD,  32'hFFFF_FFDF,  0);
        run_op(3'd6, 32'd100,        32'hFFFF_FFFD,  32'd1,          0);
        run_op(3'd5, 32'd100,        32'd3,          32'd33,         0);
        run_op(3'd7, 32'd100,        32'd3,          32'd1,          0);
        run_op(3'd5, 32'd100,        32'd0,          32'hFFFF_FFFF,  0);
        run_op(3'd7, 32'd100,        32'd0,          32'd100,        0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0);
        run_op(3'd4, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  0);
        run_op(3'd6, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  0);

        // Back-pressure: respReady held low for 5 cycles in DONE
        run_op(3'd0, 32'd7,          32'd6,          32'd42,         5);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.op       = 3'd4;
        bus.srcA     = 32'd1000;
        bus.srcB     = 32'd7;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        t_check("abort_resp_valid", bus.respValid, 0);
        t_check("abort_req_ready", bus.reqReady, 1);
        t_check("abort_busy", bus.busy, 0);
        t_check("abort_result", bus.result, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        t_check("abort_no_response", bus.respValid, 0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, ref_result(op, a, b), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port reqValid  input  1  request present.
REQ-005 SHALL have port reqReady  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 SHALL have port srcA  input  XLEN  dividend or multiplicand.
REQ-008 SHALL have port srcB  input  XLEN  divisor or multiplier.
REQ-009 SHALL have port respValid  output  1  result available.
REQ-010 SHALL have port respReady  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-014 SHALL assert reqReady only in IDLE.
REQ-015 SHALL accept a request on a rising edge with reqValid && reqReady, registering op, srcA and srcB.
REQ-016 SHALL ignore op, srcA and srcB outside the accept edge.
REQ-017 SHALL run iterative ops as a 32-step radix-2 shift-add multiply or restoring divide on unsigned magnitudes, with one sign fix-up cycle.
REQ-018 SHALL assert respValid exactly 33 cycles after the accept edge for iterative ops.
REQ-019 SHALL return the low 32 bits of the product for MUL.
REQ-020 SHALL return the high 32 bits of the 64-bit product for MULH (signed x signed), MULHSU (signed srcA x unsigned srcB) and MULHU (unsigned x unsigned).
REQ-021 SHALL truncate DIV and DIVU toward zero; REM and REMU SHALL take the sign of the dividend.
REQ-022 SHALL handle divide-by-zero by going IDLE->DONE with respValid 1 cycle after accept: quotient 0xFFFFFFFF, remainder = srcA.
REQ-023 SHALL handle signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) with 1-cycle latency: DIV returns 0x80000000, REM returns 0.
REQ-024 SHALL, in DONE, hold respValid and result stable until respReady is high; DONE->IDLE on that edge.
REQ-025 SHALL NOT accept a new request on the same edge as the response handshake; the earliest accept is the next cycle.
REQ-026 SHALL NOT affect state by respReady outside DONE.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, reqReady 1, respValid 0, busy 0 and result 0, regardless of state (including mid-CALC).
REQ-028 SHALL discard any in-flight operation on reset; no response SHALL be produced for it.

Configuration
REQ-029 SHALL, with MULDIV_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 64-bit multiplier, respValid 1 cycle after accept.
REQ-030 SHALL, without MULDIV_FAST_MUL_EN, use the 33-cycle iterative path for all multiply ops.
REQ-031 SHALL keep divide behaviour and latency independent of MULDIV_FAST_MUL_EN.

Structure
REQ-032 SHALL place the op encoding constants (3-bit, MUL=0 .. REMU=7), XLEN and the FSM state encoding in shared package muldiv_pkg.
REQ-033 SHALL use one sub-module, muldiv_signadj: operand absolute values and the final conditional negation.

Verification
REQ-034 MUL 10 x 20 -> result 200, respValid at accept+33 (accept+1 with MULDIV_FAST_MUL_EN).
REQ-035 MULH 100000 x 0xFFFFFFFE -> 0xFFFFFFFF; MULHSU 0xFFFFFFF6 x 3 -> 0xFFFFFFFF; MULHU 300000 x 2000 -> 0.
REQ-036 DIV 100 / 0xFFFFFFFD -> 0xFFFFFFDF; REM same operands -> 1; DIVU 100 / 3 -> 33; REMU -> 1.
REQ-037 DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, each at accept+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 respReady held low 5 cycles in DONE -> respValid and result unchanged, reqReady 0; then respReady=1 -> IDLE, reqReady 1 next cycle.
REQ-039 reset pulsed at accept+10 of a DIV -> respValid 0, reqReady 1 immediately; the following MUL 3 x 4 -> 12.
